cpe_serial_tx: RTL
==================

Name: cpe_serial_tx

Overview:
Serial transmitter for the 15-bit CPE codeword (cyclic (15,7) BCH, g(x)=x^8+x^7+x^6+x^4+1). It is the bit-serial encoding end of the link whose parallel detector/corrector sit on the receive side.
- Accepts 7-bit data words over a valid/ready handshake.
- Computes the 8 parity bits on the fly with an LFSR divider.
- Shifts the 15-bit codeword out one bit per accepted beat, with back-pressure.
- An optional error-injection mask flips selected output bits so the detector/corrector can be exercised.

Parameters:
- NBIT, 7, data bits per word.
- NCODE, 15, codeword length.
- NPAR, 8, parity bits (NCODE-NBIT).
- GPOLY, 8'b1101_0001, low 8 coefficients of g(x); bit k = coefficient of x^k; the x^8 term is implicit.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  data word offered.
- in_ready  out  1  block can accept a word.
- in_data  in  NBIT  data; in_data[k] = coefficient of x^(14-k).
- in_inj  in  NCODE  error-injection mask, captured with in_data.
- tx_valid  out  1  tx_bit is valid.
- tx_ready  in  1  downstream accepts tx_bit this cycle.
- tx_bit  out  1  serial code bit; code[0] is sent first (highest degree first).
- tx_sop  out  1  high with code[0].
- tx_eop  out  1  high with code[14].
- code_out  out  NCODE  parallel clean codeword of the last completed frame, without injection.
- done  out  1  one-cycle pulse after the code[14] beat is accepted.

Behaviour:
- Codeword layout:
  - code[i] = coefficient of x^(14-i).
  - code[6:0] = data.
  - code[14:7] = r(x) = x^8·d(x) mod g(x), with code[7+j] = coefficient of x^(7-j).
- States:
  - IDLE: in_ready=1, tx_valid=0.
  - DATA: 7 beats.
  - PARITY: 8 beats.
- Transitions:
  - IDLE→DATA when in_valid&in_ready. Capture in_data and in_inj, clear LFSR r[7:0], set bit index=0.
  - A beat is accepted when tx_valid&tx_ready. The index increments only on an accepted beat. tx_bit, tx_sop and tx_eop stay stable while tx_ready=0.
  - DATA beat i: tx_bit = data[i]^inj[i]. On accept: fb = data[i]^r[7]; r <= {r[6:0],0} ^ (fb ? GPOLY : 0). After i=6 is accepted, go to PARITY.
  - PARITY beat j (index 7+j): tx_bit = r[7-j]^inj[7+j]. The LFSR is frozen; parity is read directly from r.
  - After the index-14 beat is accepted: go to IDLE, pulse done for one cycle, update code_out.
- Latency: word accepted in cycle N → code[0] valid in cycle N+1. Minimum frame is 15 cycles. in_ready=0 from N+1 until done.
- No overlap: the next word can be accepted in the cycle done is high at the earliest (state IDLE). Back-to-back frames have a 1-cycle gap.
- tx_sop=1 exactly at index 0; tx_eop=1 exactly at index 14; both are 0 otherwise.
- Injection affects tx_bit only, never the LFSR or code_out.
- Reset:
  - All outputs go to 0 except in_ready, which is 1 (IDLE).
  - code_out=0, LFSR=0, index=0.
  - Reset mid-frame aborts the frame with no done and no code_out update. The next frame starts clean.
- in_valid while busy is ignored; no word is accepted.

Decomposition:
- Shared package cpe_pkg holds:
  - constants NBIT, NCODE, NPAR, GPOLY;
  - the state enum {IDLE, DATA, PARITY};
  - the index width constant (4 bits).
- One natural sub-module, cpe_lfsr_div: an 8-bit GPOLY divider with clear, enable, in_bit and rem outputs, reusable by a future serial syndrome checker.

Test Plan:
- in_data=7'h00, inj=0, tx_ready=1 → 15 zero bits; sop at beat 0, eop at beat 14; done in the cycle after beat 14; code_out=15'h0000.
- in_data=7'b1000000 (x^8 only), inj=0 → parity code[14:7]=8'b1000_1011, so code_out=15'b100010111000000 (codeword = g(x)); serial stream matches code[0..14].
- in_data=7'h7F, inj=0 → all 15 bits are 1; code_out=15'h7FFF (all-ones is a codeword).
- Same as the x^8 case with tx_ready toggled pseudo-randomly (50%) → identical bit sequence; bits held stable during stalls; in_ready=0 throughout; done occurs exactly once.
- Random data with inj=15'h0101 → tx_bit[0] and tx_bit[8] inverted vs a reference model; code_out clean; the downstream parallel detector flags an error and the corrector restores the clean code.
- rst asserted at DATA beat 3, then a new word 7'h55 → no done for the aborted frame; the new frame's code_out equals the model for 7'h55; sop is re-asserted on its beat 0.

Source files
------------

// File: rtl/cpe_pkg.sv
// Shared constants, state encoding and helpers for the CPE (15,7) BCH serial link.
package cpe_pkg;

  localparam int unsigned NBIT  = 7;
  localparam int unsigned NCODE = 15;
  localparam int unsigned NPAR  = NCODE - NBIT;
  localparam int unsigned IDXW  = 4;

  // Low 8 coefficients of g(x) = x^8+x^7+x^6+x^4+1; the x^8 term is implicit.
  localparam logic [NPAR-1:0] GPOLY = 8'b1101_0001;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  // Remainder register holds x^7 at bit 7, codeword holds x^7 at code[7]; reverse to map.
  function automatic logic [NPAR-1:0] rev_par(input logic [NPAR-1:0] r);
    logic [NPAR-1:0] o;
    o = '0;
    for (int unsigned k = 0; k < NPAR; k++) o[k] = r[NPAR-1-k];
    return o;
  endfunction

endpackage

// File: rtl/cpe_lfsr_div.sv
// Bit-serial polynomial divider: remainder of the shifted-in stream times x^8 modulo g(x).
module cpe_lfsr_div
  import cpe_pkg::*;
#(
  parameter logic [NPAR-1:0] POLY = GPOLY
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  input  logic            in_bit,
  output logic [NPAR-1:0] rem
);

  logic fb;

  assign fb = in_bit ^ rem[NPAR-1];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rem <= '0;
    end else if (enable) begin
      rem <= {rem[NPAR-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/cpe_serial_tx.sv
// Serial CPE codeword transmitter: 7 data beats then 8 parity beats, valid/ready on both sides.
module cpe_serial_tx
  import cpe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBIT-1:0]  in_data,
  input  logic [NCODE-1:0] in_inj,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_bit,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic [NCODE-1:0] code_out,
  output logic             done
);

  state_t           state, state_nxt;
  logic [IDXW-1:0]  idx;
  logic [NBIT-1:0]  data_q;
  logic [NCODE-1:0] inj_q;
  logic [NPAR-1:0]  rem;
  logic [2:0]       ridx;
  logic             accept, last_beat;
  logic             lfsr_clr, lfsr_en, lfsr_in;

  cpe_lfsr_div #(.POLY(GPOLY)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clear  (lfsr_clr),
    .enable (lfsr_en),
    .in_bit (lfsr_in),
    .rem    (rem)
  );

  assign accept    = tx_valid & tx_ready;
  assign last_beat = (idx == 4'(NCODE - 1));
  // Parity beat at idx 7..14 reads rem[14-idx]; idx[2:0] wraps 7,0..6 so 6-idx[2:0] gives 7..0.
  assign ridx      = 3'd6 - idx[2:0];

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_bit    = 1'b0;
    lfsr_clr  = 1'b0;
    lfsr_en   = 1'b0;
    lfsr_in   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = DATA;
          lfsr_clr  = 1'b1;
        end
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_bit   = data_q[idx[2:0]] ^ inj_q[idx];
        lfsr_in  = data_q[idx[2:0]];
        lfsr_en  = accept;
        if (accept && idx == 4'(NBIT - 1)) state_nxt = PARITY;
      end
      PARITY: begin
        tx_valid = 1'b1;
        tx_bit   = rem[ridx] ^ inj_q[idx];
        if (accept && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_sop = tx_valid && (idx == '0);
  assign tx_eop = tx_valid && last_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      data_q   <= '0;
      inj_q    <= '0;
      code_out <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == IDLE && in_valid) begin
        data_q <= in_data;
        inj_q  <= in_inj;
        idx    <= '0;
      end else if (accept) begin
        idx <= last_beat ? '0 : idx + 4'd1;
      end
      if (state == PARITY && accept && last_beat) begin
        done     <= 1'b1;
        code_out <= {rev_par(rem), data_q};
      end
    end
  end

endmodule
